ms_interval_timer: RTL
======================

Name: ms_interval_timer

Overview:
- Consumer of the 1 ms timeout pulse produced by the LFSR 1 ms counter (l_f_s_r_count_1ms).
- Counts those pulses to time a programmable interval in milliseconds, for example the per-character response window in the Braille trainer.
- Supports one-shot and periodic modes, with start/stop control and a one-cycle done pulse.
- Sits between the 1 ms tick source and the trainer control FSM.

Parameters:
- CNT_W, 16: width of the duration and remaining-time counters, in ms.
- EXP_W, 8: width of the periodic expiry counter.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous reset, active-low.
- tick_1ms  in  1  1 ms timeout pulse from the LFSR counter. May be high for one or more cycles.
- start  in  1  level sampled each clock; start/restart request.
- stop  in  1  level sampled each clock; abort request.
- periodic  in  1  mode select, sampled only when start is accepted. 1 = auto-reload.
- duration_ms  in  CNT_W  interval length, sampled only when start is accepted.
- busy  out  1  timer running.
- done  out  1  one-cycle expiry pulse.
- remaining_ms  out  CNT_W  milliseconds left in the current interval.
- expiry_cnt  out  EXP_W  expiries since the last accepted start (periodic mode).

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - busy=0, done=0, remaining_ms=0, expiry_cnt=0.
  - Internal tick_q=0, dur_r=0, per_r=0.
  - All registers update on the posedge of clk only when rst=1. Reset asserted mid-interval aborts immediately and produces no done pulse.
- Tick qualification:
  - tick_rise = tick_1ms & ~tick_q, with tick_q registered every cycle.
  - A tick held high for N cycles counts exactly once.
- States: IDLE and RUN. done is a registered pulse and is not a separate state. done defaults to 0 every cycle unless set below.
- Priority per edge: stop > start > tick_rise.
- IDLE:
  - start=1, duration_ms != 0:
    - Latch dur_r=duration_ms, per_r=periodic.
    - Set remaining_ms=duration_ms and expiry_cnt=0, then go to RUN.
    - busy=1 from the next cycle.
  - start=1, duration_ms == 0:
    - done=1 for exactly the next cycle; stay in IDLE with busy=0.
    - expiry_cnt=1, remaining_ms=0.
  - stop and tick_rise are ignored.
- RUN:
  - stop=1: go to IDLE. busy=0 and remaining_ms=0 next cycle; no done. expiry_cnt is held.
  - start=1 (without stop): restart. Reload from the current duration_ms and periodic, apply the zero-duration rule above, and set expiry_cnt=0. A tick_rise in the same cycle is discarded.
  - tick_rise with remaining_ms > 1: remaining_ms decrements by 1.
  - tick_rise with remaining_ms == 1:
    - done=1 next cycle.
    - expiry_cnt increments and wraps from 2^EXP_W-1 to 0.
    - per_r=0: go to IDLE, busy=0 and remaining_ms=0 on the same edge as done rises.
    - per_r=1: remaining_ms=dur_r, stay in RUN with busy=1. No gap: periodic intervals are exactly dur_r ticks apart.
- Accuracy: the first interval after start spans between duration-1 and duration ms, because the tick phase is free-running. This is documented and accepted.
- Latency: done rises in the cycle after the clock edge that samples the final tick_rise.
- Width rule: remaining_ms never underflows and never exceeds dur_r.

Decomposition:
- Shared package timer_pkg:
  - State encoding: IDLE=1'b0, RUN=1'b1.
  - Default CNT_W and EXP_W.
  - Constant CLK_PER_MS=50000, shared with the LFSR counter and benches.
- One sub-module, tick_edge_det: 1-bit rising-edge detector (clk, rst, in, rise), reused for button inputs elsewhere.

Test Plan:
- Tick every 5 cycles; start with duration_ms=3, periodic=0 -> busy=1, remaining goes 3,2,1; done pulses once on the cycle after the 3rd tick_rise; busy=0, remaining=0, expiry_cnt=1.
- Periodic=1, duration_ms=2, 7 ticks -> done pulses after ticks 2, 4 and 6; expiry_cnt=3; busy stays 1 and remaining_ms=1 after tick 7.
- Start with duration_ms=0 -> done=1 for exactly one cycle; busy never asserts; expiry_cnt=1.
- Running at remaining=2; stop and tick_rise in the same cycle -> IDLE, remaining=0, no done. Start and tick in the same cycle -> remaining reloads to duration_ms with no decrement.
- tick_1ms held high for 4 cycles -> exactly one decrement.
- rst=0 asserted mid-interval (remaining=5) -> all outputs are 0 immediately; no done after rst=1; tick_rise ignored until the next start.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared constants and state encoding for the ms interval timer,
// the LFSR 1 ms tick source and their benches.
// Ports: none (package only).
package timer_pkg;

  localparam int CNT_W_DEF  = 16;     // default duration / remaining width (ms)
  localparam int EXP_W_DEF  = 8;      // default periodic expiry counter width
  localparam int CLK_PER_MS = 50000;  // 50 MHz core clock cycles per millisecond

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/tick_edge_det.sv
// tick_edge_det: 1-bit rising-edge detector; a level held high for N cycles
// yields a single-cycle rise pulse. Combinational output, one register.
// Ports: clk, rst (async active-low), in (level), rise (one-cycle pulse).
module tick_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic in_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in;
    end
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/ms_interval_timer.sv
// ms_interval_timer: counts qualified 1 ms ticks to time a programmable
// interval, one-shot or periodic, with start/stop and a one-cycle done pulse.
// Ports: clk, rst (async active-low), tick_1ms, start, stop, periodic,
//        duration_ms -> busy, done, remaining_ms, expiry_cnt.
module ms_interval_timer
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int EXP_W = EXP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1ms,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [CNT_W-1:0] duration_ms,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining_ms,
  output logic [EXP_W-1:0] expiry_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic [EXP_W-1:0] expiry_q, expiry_d;
  logic             per_q, per_d;
  logic             done_q, done_d;
  logic             tick_rise;

  // A long tick pulse must count only once.
  tick_edge_det u_tick_edge (
    .clk  (clk),
    .rst  (rst),
    .in   (tick_1ms),
    .rise (tick_rise)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      dur_q       <= '0;
      expiry_q    <= '0;
      per_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      dur_q       <= dur_d;
      expiry_q    <= expiry_d;
      per_q       <= per_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    dur_d       = dur_q;
    expiry_d    = expiry_q;
    per_d       = per_q;
    done_d      = 1'b0;

    // stop only matters while running; start (re)loads from either state.
    if (state_q == RUN && stop) begin
      state_d     = IDLE;
      remaining_d = '0;
    end else if (start) begin
      dur_d    = duration_ms;
      per_d    = periodic;
      expiry_d = '0;
      if (duration_ms == '0) begin
        // Zero-length interval expires at once without ever running.
        state_d     = IDLE;
        remaining_d = '0;
        done_d      = 1'b1;
        expiry_d    = EXP_W'(1);
      end else begin
        state_d     = RUN;
        remaining_d = duration_ms;
      end
    end else if (state_q == RUN && tick_rise) begin
      if (remaining_q > CNT_W'(1)) begin
        remaining_d = remaining_q - CNT_W'(1);
      end else begin
        // Final tick: reload on the same edge so periodic intervals are gapless.
        done_d   = 1'b1;
        expiry_d = expiry_q + EXP_W'(1);
        if (per_q) begin
          remaining_d = dur_q;
        end else begin
          state_d     = IDLE;
          remaining_d = '0;
        end
      end
    end
  end

  assign busy         = (state_q == RUN);
  assign done         = done_q;
  assign remaining_ms = remaining_q;
  assign expiry_cnt   = expiry_q;

endmodule
